// File: rtl/cache_miss_ctrl_if.sv
// Requester and main-memory handshake bundle for the cache miss controller.
// The slave modport is the controller's view; master is the requester/memory side.
interface cache_miss_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              MemRead;
  logic [31:0]       rdAddr;
  logic              MemHit;
  logic              MemReadReady;
  logic              MemReadDone;
  logic              MemError;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  MemRead, rdAddr, MemHit, mem_ready, mem_rdata,
    output MemReadReady, MemReadDone, MemError, mem_req, mem_addr
  );

  modport master (
    output MemRead, rdAddr, MemHit, mem_ready, mem_rdata,
    input  MemReadReady, MemReadDone, MemError, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss-handling controller between a direct-mapped cache and main memory:
// acks hits, fetches and fills missed lines, counts hits/misses, flags memory timeouts.
module cache_miss_ctrl #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 26,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  cache_miss_ctrl_if.slave   bus,
  output logic               fill_en,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [DATA_W-1:0]  fill_data,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HIT_ACK = 3'd1;
  localparam logic [2:0] REQ     = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] FILL    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam int              TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic             err;
  logic [31:0]      addr_q;

  // Timer counts WAIT cycles; the last one is cycle 1+TIMEOUT after the request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      err        <= 1'b0;
      addr_q     <= '0;
      fill_data  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.MemRead) begin
            if (bus.MemHit) begin
              state <= HIT_ACK;
            end else begin
              addr_q <= bus.rdAddr;
              err    <= 1'b0;
              state  <= REQ;
            end
          end
        end
        HIT_ACK: begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
          state <= IDLE;
        end
        REQ: begin
          timer <= '0;
          if (bus.mem_ready) begin
            fill_data <= bus.mem_rdata;
            state     <= FILL;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ready) begin
            fill_data <= bus.mem_rdata;
            state     <= FILL;
          end else if (timer == TMR_LAST) begin
            err   <= 1'b1;
            state <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FILL: state <= DONE;
        DONE: begin
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.MemReadReady = (state == IDLE);
  assign bus.MemReadDone  = (state == HIT_ACK) || (state == DONE);
  assign bus.MemError     = (state == DONE) && err;
  assign bus.mem_req      = (state == REQ);
  assign bus.mem_addr     = addr_q;
  assign fill_en          = (state == FILL);
  assign fill_index       = addr_q[INDEX_W-1:0];
  assign fill_tag         = addr_q[31:INDEX_W];

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed self-checking bench for cache_miss_ctrl: hits, misses at several
// latencies, timeout, reset mid-miss, and counter saturation on a narrow build.
module tb_cache_miss_ctrl;

  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  cache_miss_ctrl_if #(.DATA_W(32)) bus  ();
  cache_miss_ctrl_if #(.DATA_W(32)) bus2 ();

  logic        fill_en,  fill_en2;
  logic [5:0]  fill_index, fill_index2;
  logic [25:0] fill_tag, fill_tag2;
  logic [31:0] fill_data, fill_data2;
  logic [15:0] hit_count, miss_count;
  logic [2:0]  hit_count2, miss_count2;

  cache_miss_ctrl #(.INDEX_W(6), .TAG_W(26), .DATA_W(32), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .fill_en(fill_en), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  cache_miss_ctrl #(.INDEX_W(6), .TAG_W(26), .DATA_W(32), .TIMEOUT(TIMEOUT), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave),
    .fill_en(fill_en2), .fill_index(fill_index2), .fill_tag(fill_tag2),
    .fill_data(fill_data2), .hit_count(hit_count2), .miss_count(miss_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.MemRead = 1'b1; bus.MemHit = 1'b0; bus.rdAddr = 32'hFFFF_FFFF;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1111_1111;
    tick(); tick();
    reset = 1'b0;
    bus.MemRead = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.MemReadReady !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.MemReadReady); end
    checks++; if (bus.MemReadDone !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.MemReadDone); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (fill_en !== 1'b0) begin failures++; $display("FAIL reset_fill_en got=%b exp=0", fill_en); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (fill_data !== 32'h0) begin failures++; $display("FAIL reset_fill_data got=%h exp=0", fill_data); end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    tick();
  endtask

  task automatic test_hit;
    for (int c = 0; c <= 2; c++) begin
      bus.MemRead = (c <= 1); bus.MemHit = 1'b1; bus.rdAddr = 32'h0000_0040;
      @(negedge clk);
      checks++; if (bus.MemReadDone !== (c == 1)) begin failures++; $display("FAIL hit_done c=%0d got=%b exp=%b", c, bus.MemReadDone, (c == 1)); end
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL hit_mem_req c=%0d got=%b exp=0", c, bus.mem_req); end
      if (c == 1) begin
        checks++; if (bus.MemError !== 1'b0) begin failures++; $display("FAIL hit_error got=%b exp=0", bus.MemError); end
      end
      if (c == 2) begin
        checks++; if (hit_count !== 16'd1) begin failures++; $display("FAIL hit_count got=%0d exp=1", hit_count); end
      end
      tick();
    end
    bus.MemRead = 1'b0;
  endtask

  // One miss: mem_ready at cycle 1+lat (never when tmo); checks every cycle against spec latencies.
  task automatic test_miss(input logic [31:0] addr, input int lat, input logic [31:0] data,
                           input bit tmo, input logic [5:0] expIdx, input logic [25:0] expTag,
                           input int expMiss);
    int doneCycle;
    int fillCycle;
    doneCycle = tmo ? 2 + TIMEOUT : 3 + lat;
    fillCycle = tmo ? -1 : 2 + lat;
    for (int c = 0; c <= doneCycle + 1; c++) begin
      bus.MemRead   = (c <= doneCycle);
      bus.MemHit    = (c != 0);
      bus.rdAddr    = (c == 0) ? addr : ~addr;
      bus.mem_ready = !tmo && (c == 1 + lat);
      bus.mem_rdata = bus.mem_ready ? data : 32'hBAD0_0000 + c;
      @(negedge clk);
      checks++; if (bus.MemReadReady !== (c == 0 || c == doneCycle + 1)) begin failures++; $display("FAIL miss_ready c=%0d got=%b", c, bus.MemReadReady); end
      checks++; if (bus.mem_req !== (c == 1)) begin failures++; $display("FAIL miss_mem_req c=%0d got=%b exp=%b", c, bus.mem_req, (c == 1)); end
      checks++; if (fill_en !== (c == fillCycle)) begin failures++; $display("FAIL miss_fill_en c=%0d got=%b exp=%b", c, fill_en, (c == fillCycle)); end
      checks++; if (bus.MemReadDone !== (c == doneCycle)) begin failures++; $display("FAIL miss_done c=%0d got=%b exp=%b", c, bus.MemReadDone, (c == doneCycle)); end
      if (c == 1) begin
        checks++; if (bus.mem_addr !== addr) begin failures++; $display("FAIL miss_mem_addr got=%h exp=%h", bus.mem_addr, addr); end
      end
      if (c == fillCycle) begin
        checks++; if (fill_index !== expIdx || fill_tag !== expTag || fill_data !== data) begin
          failures++; $display("FAIL miss_fill_fields got=%h/%h/%h exp=%h/%h/%h", fill_index, fill_tag, fill_data, expIdx, expTag, data);
        end
      end
      if (c == doneCycle) begin
        checks++; if (bus.MemError !== tmo) begin failures++; $display("FAIL miss_error got=%b exp=%b", bus.MemError, tmo); end
      end
      if (c == doneCycle + 1) begin
        checks++; if (miss_count !== 16'(expMiss)) begin failures++; $display("FAIL miss_count got=%0d exp=%0d", miss_count, expMiss); end
      end
      tick();
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_late_ready;
    for (int c = 0; c < 3; c++) begin
      bus.mem_ready = (c < 2); bus.mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      checks++; if (fill_en !== 1'b0 || bus.MemReadDone !== 1'b0 || bus.MemReadReady !== 1'b1) begin
        failures++; $display("FAIL late_ready c=%0d fill=%b done=%b ready=%b exp=0/0/1", c, fill_en, bus.MemReadDone, bus.MemReadReady);
      end
      tick();
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 5; c++) begin
      bus.MemRead = (c < 4); bus.MemHit = 1'b1; bus.rdAddr = 32'h0000_0100 + c;
      @(negedge clk);
      checks++; if (bus.MemReadDone !== (c == 1 || c == 3)) begin failures++; $display("FAIL b2b_done c=%0d got=%b", c, bus.MemReadDone); end
      tick();
    end
    bus.MemRead = 1'b0;
    @(negedge clk);
    checks++; if (hit_count !== 16'd3) begin failures++; $display("FAIL b2b_hit_count got=%0d exp=3", hit_count); end
    tick();
  endtask

  task automatic test_reset_in_wait;
    bus.MemRead = 1'b1; bus.MemHit = 1'b0; bus.rdAddr = 32'hA5A5_0003;
    tick(); tick();
    @(negedge clk);
    checks++; if (bus.MemReadReady !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_wait_pre ready=%b req=%b exp=0/0", bus.MemReadReady, bus.mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.MemRead = 1'b0;
    @(negedge clk);
    checks++; if (bus.MemReadReady !== 1'b1 || bus.mem_addr !== 32'h0 || bus.MemReadDone !== 1'b0) begin
      failures++; $display("FAIL rst_wait_idle ready=%b addr=%h done=%b exp=1/0/0", bus.MemReadReady, bus.mem_addr, bus.MemReadDone);
    end
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin failures++; $display("FAIL rst_wait_counts got=%0d/%0d exp=0/0", hit_count, miss_count); end
    tick();
    for (int c = 0; c < 2; c++) begin
      bus.mem_ready = (c == 0); bus.mem_rdata = 32'h7777_7777;
      @(negedge clk);
      checks++; if (fill_en !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL rst_wait_stale c=%0d fill=%b req=%b exp=0/0", c, fill_en, bus.mem_req); end
      tick();
    end
    bus.mem_ready = 1'b0;
    test_miss(32'h0000_0FC1, 2, 32'h0BAD_CAFE, 1'b0, 6'h01, 26'h000003F, 1);
  endtask

  task automatic test_saturation;
    for (int c = 0; c <= 22; c++) begin
      bus2.MemRead = (c < 22); bus2.MemHit = 1'b1; bus2.rdAddr = 32'h0000_0040;
      @(negedge clk);
      if (c == 12) begin
        checks++; if (hit_count2 !== 3'd6) begin failures++; $display("FAIL sat_mid got=%0d exp=6", hit_count2); end
      end
      if (c == 22) begin
        checks++; if (hit_count2 !== 3'd7) begin failures++; $display("FAIL sat_hold got=%0d exp=7", hit_count2); end
        checks++; if (miss_count2 !== 3'd0) begin failures++; $display("FAIL sat_miss got=%0d exp=0", miss_count2); end
      end
      tick();
    end
    bus2.MemRead = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.MemRead = 1'b0; bus.MemHit = 1'b0; bus.rdAddr = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    bus2.MemRead = 1'b0; bus2.MemHit = 1'b0; bus2.rdAddr = '0; bus2.mem_ready = 1'b0; bus2.mem_rdata = '0;
    tick();
    test_reset();
    test_hit();
    test_miss(32'h1234_5687, 3, 32'hDEAD_BEEF, 1'b0, 6'h07, 26'h048D15A, 1);
    test_miss(32'hFFFF_FFFF, 0, 32'h0123_4567, 1'b0, 6'h3F, 26'h3FFFFFF, 2);
    test_miss(32'h8000_0040, 0, 32'h0, 1'b1, 6'h00, 26'h2000001, 3);
    test_late_ready();
    test_miss(32'h0000_0082, TIMEOUT, 32'h5A5A_A5A5, 1'b0, 6'h02, 26'h0000002, 4);
    test_back_to_back();
    test_reset_in_wait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
